// File: rtl/ark_xor_serial_if.sv
// -----------------------------------------------------------------------------
// ark_xor_serial_if
// Handshake/data bundle for the serial AddRoundKey unit.
//   slave  modport : view of the AddRoundKey unit itself
//   master modport : view of the upstream/downstream environment
// Signals:
//   i_valid  / o_ready : input handshake (state + key offered / accepted)
//   iv_state / iv_key  : ROWS*ROW_W packed state and round key, row r = [r*ROW_W +: ROW_W]
//   i_key_en           : 1 applies the key, 0 bypasses it (key taken as zero)
//   o_valid  / i_ready : output handshake (result offered / consumed)
//   ov_data            : result, same packing as iv_state
//   o_busy             : unit is stepping through slices
// -----------------------------------------------------------------------------
interface ark_xor_serial_if #(
    parameter int ROWS  = 4,
    parameter int ROW_W = 16
);
    logic                    i_valid;
    logic                    o_ready;
    logic [ROWS*ROW_W-1:0]   iv_state;
    logic [ROWS*ROW_W-1:0]   iv_key;
    logic                    i_key_en;
    logic                    o_valid;
    logic                    i_ready;
    logic [ROWS*ROW_W-1:0]   ov_data;
    logic                    o_busy;

    modport slave (
        input  i_valid, iv_state, iv_key, i_key_en, i_ready,
        output o_ready, o_valid, ov_data, o_busy
    );

    modport master (
        output i_valid, iv_state, iv_key, i_key_en, i_ready,
        input  o_ready, o_valid, ov_data, o_busy
    );
endinterface

// File: rtl/ark_xor_serial.sv
// -----------------------------------------------------------------------------
// ark_xor_serial
// Serial AddRoundKey: XORs a ROWS x ROW_W cipher state with a round key of the
// same shape, SLICE_W bits per row per cycle. Each BUSY cycle XORs the low
// slice of every row and rotates state and key right by SLICE_W, so after
// SLICES cycles each row is back in its original alignment holding state^key.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   ark_bus  : ark_xor_serial_if.slave (valid/ready in, data out, busy)
// Parameters:
//   ROWS, ROW_W : state shape
//   SLICE_W     : bits per row processed per cycle, must divide ROW_W
// -----------------------------------------------------------------------------
module ark_xor_serial #(
    parameter int ROWS    = 4,
    parameter int ROW_W   = 16,
    parameter int SLICE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    ark_xor_serial_if.slave     ark_bus
);

    localparam int DATA_W = ROWS * ROW_W;
    localparam int SLICES = ROW_W / SLICE_W;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);

    if ((ROW_W % SLICE_W) != 0) begin : g_bad_slice
        $error("ark_xor_serial: ROW_W must be a multiple of SLICE_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t               fsm_q;
    logic [DATA_W-1:0]  st_q;
    logic [DATA_W-1:0]  ky_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;
    logic               busy_q;

    logic [DATA_W-1:0]  st_d;
    logic [DATA_W-1:0]  ky_d;
    logic [DATA_W-1:0]  ky_load_s;
    logic               ready_s;
    logic               accept_s;

    // In DONE the result slot frees up in the same cycle the consumer takes it,
    // so a new input can be taken on that edge (combinational i_ready path).
    assign ready_s   = (fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & ark_bus.i_ready);
    assign accept_s  = ark_bus.i_valid & ready_s;
    assign ky_load_s = ark_bus.i_key_en ? ark_bus.iv_key : {DATA_W{1'b0}};

    // Per-row slice step: XOR the low slice and rotate right by one slice.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        if (SLICES == 1) begin : g_single
            // Full-width slice: one XOR, key rotation by the full row is identity.
            assign st_d[r*ROW_W +: ROW_W] = st_q[r*ROW_W +: ROW_W] ^ ky_q[r*ROW_W +: ROW_W];
            assign ky_d[r*ROW_W +: ROW_W] = ky_q[r*ROW_W +: ROW_W];
        end else begin : g_multi
            logic [ROW_W-1:0] st_row_s;
            logic [ROW_W-1:0] ky_row_s;
            assign st_row_s = st_q[r*ROW_W +: ROW_W];
            assign ky_row_s = ky_q[r*ROW_W +: ROW_W];
            assign st_d[r*ROW_W +: ROW_W] = {st_row_s[SLICE_W-1:0] ^ ky_row_s[SLICE_W-1:0],
                                             st_row_s[ROW_W-1:SLICE_W]};
            assign ky_d[r*ROW_W +: ROW_W] = {ky_row_s[SLICE_W-1:0],
                                             ky_row_s[ROW_W-1:SLICE_W]};
        end
    end

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q   <= ST_IDLE;
            st_q    <= {DATA_W{1'b0}};
            ky_q    <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        st_q    <= ark_bus.iv_state;
                        ky_q    <= ky_load_s;
                        cnt_q   <= {CNT_W{1'b0}};
                        fsm_q   <= ST_BUSY;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        fsm_q   <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    st_q  <= st_d;
                    ky_q  <= ky_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        fsm_q   <= ST_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        fsm_q   <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (ark_bus.i_ready) begin
                        valid_q <= 1'b0;
                        if (ark_bus.i_valid) begin
                            st_q   <= ark_bus.iv_state;
                            ky_q   <= ky_load_s;
                            cnt_q  <= {CNT_W{1'b0}};
                            fsm_q  <= ST_BUSY;
                            busy_q <= 1'b1;
                        end else begin
                            fsm_q  <= ST_IDLE;
                        end
                    end else begin
                        fsm_q <= ST_DONE;
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ark_bus.o_ready = ready_s;
    assign ark_bus.o_valid = valid_q;
    assign ark_bus.ov_data = st_q;
    assign ark_bus.o_busy  = busy_q;

endmodule
